// File: rtl/pe_cell.sv
// Systolic-array processing element: forwards a/b/c to its neighbours
// and keeps two wrapping multiply-accumulate sums sharing operand a.
`timescale 1ns/1ps
module pe_cell #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic [WIDTH-1:0]   e,
  output logic [WIDTH-1:0]   f,
  output logic [WIDTH-1:0]   g,
  output logic [2*WIDTH-1:0] acc1,
  output logic [2*WIDTH-1:0] acc2
);

  localparam int AW = 2 * WIDTH;

  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [AW-1:0]    acc1_q, acc1_d;
  logic [AW-1:0]    acc2_q, acc2_d;
  logic [AW-1:0]    prod1;
  logic [AW-1:0]    prod2;

  // Zero-extend before multiplying so the full product survives.
  always_comb begin
    prod1 = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    prod2 = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, c};
  end

  always_comb begin
    e_d    = e_q;
    f_d    = f_q;
    g_d    = g_q;
    acc1_d = acc1_q;
    acc2_d = acc2_q;
    if (enable) begin
      e_d    = a;
      f_d    = b;
      g_d    = c;
      acc1_d = acc1_q + prod1;
      acc2_d = acc2_q + prod2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q    <= '0;
      f_q    <= '0;
      g_q    <= '0;
      acc1_q <= '0;
      acc2_q <= '0;
    end else begin
      e_q    <= e_d;
      f_q    <= f_d;
      g_q    <= g_d;
      acc1_q <= acc1_d;
      acc2_q <= acc2_d;
    end
  end

  assign e    = e_q;
  assign f    = f_q;
  assign g    = g_q;
  assign acc1 = acc1_q;
  assign acc2 = acc2_q;

endmodule

// File: tb/tb_pe_cell.sv
// Bench for pe_cell: directed scenarios plus random traffic checked
// against an arithmetic model of forwarding and wrapping accumulation.
`timescale 1ns/1ps
module tb_pe_cell;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] a = '0, b = '0, c = '0;
  logic [7:0] e, f, g;
  logic [15:0] acc1, acc2;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  int m_e = 0, m_f = 0, m_g = 0, m_acc1 = 0, m_acc2 = 0;

  pe_cell #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .a(a), .b(b), .c(c),
    .e(e), .f(f), .g(g),
    .acc1(acc1), .acc2(acc2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_e = 0; m_f = 0; m_g = 0; m_acc1 = 0; m_acc2 = 0;
  endtask

  // Drive one cycle's inputs, take the edge, update the model, then
  // return at the following falling edge.
  task automatic tick(input bit en, input int va, input int vb, input int vc);
    enable = en;
    a = 8'(va); b = 8'(vb); c = 8'(vc);
    @(posedge clk);
    if (!reset && en) begin
      m_e = va; m_f = vb; m_g = vc;
      m_acc1 = (m_acc1 + va * vb) % 65536;
      m_acc2 = (m_acc2 + va * vc) % 65536;
    end
    @(negedge clk);
  endtask

  // Asynchronous pulse placed between a falling and the next rising edge.
  task automatic reset_pulse(input bit verify);
    #2 reset = 1'b1;
    model_zero();
    #1;
    if (verify) begin
      chk("async_rst_e", int'(e), 0);
      chk("async_rst_acc1", int'(acc1), 0);
      chk("async_rst_acc2", int'(acc2), 0);
    end
    #1 reset = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int xe, input int xf,
                         input int xg, input int x1, input int x2);
    chk({tag, "_e"}, int'(e), xe);
    chk({tag, "_f"}, int'(f), xf);
    chk({tag, "_g"}, int'(g), xg);
    chk({tag, "_acc1"}, int'(acc1), x1);
    chk({tag, "_acc2"}, int'(acc2), x2);
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_e", int'(e), m_e);
      chk("model_f", int'(f), m_f);
      chk("model_g", int'(g), m_g);
      chk("model_acc1", int'(acc1), m_acc1);
      chk("model_acc2", int'(acc2), m_acc2);
    end
  end

  initial begin
    model_zero();
    @(negedge clk);
    cmp_on = 1'b1;

    // Reset held with live inputs and enable.
    for (int i = 0; i < 3; i++)
      tick(1'b1, $urandom_range(1, 255), $urandom_range(1, 255),
           $urandom_range(1, 255));
    chk_all("rst_hold", 0, 0, 0, 0, 0);
    reset = 1'b0;

    tick(1'b1, 1, 1, 1);
    chk_all("ones", 1, 1, 1, 1, 1);

    reset_pulse(1'b0);
    tick(1'b1, 3, 4, 5);
    tick(1'b1, 3, 4, 5);
    chk_all("two_edges", 3, 4, 5, 24, 30);

    for (int i = 0; i < 3; i++) tick(1'b0, 9, 9, 9);
    chk_all("hold", 3, 4, 5, 24, 30);

    reset_pulse(1'b1);
    tick(1'b1, 255, 255, 255);
    tick(1'b1, 255, 255, 255);
    chk_all("wrap", 255, 255, 255, 16'hFC02, 16'hFC02);

    tick(1'b1, 17, 33, 200);
    tick(1'b1, 90, 7, 61);
    reset_pulse(1'b1);
    tick(1'b1, 2, 3, 4);
    chk_all("after_rst", 2, 3, 4, 6, 8);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) reset_pulse(1'b1);
      tick(1'($urandom_range(0, 3) != 0), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 255));
    end

    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
